// File: rtl/title_sequencer_pkg.sv
// Shared types and defaults for the title/game-over banner sequencer.
package title_sequencer_pkg;
   localparam int CORDW = 10;
   localparam int XW    = 10;
   localparam int CNTW  = 8;

   localparam logic [XW-1:0] START_X_DEF  = 10'd640;
   localparam logic [XW-1:0] TARGET_X_DEF = 10'd200;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SLIDE_IN = 3'd1,
      ST_HOLD     = 3'd2,
      ST_BLINK    = 3'd3,
      ST_RUN      = 3'd4
   } state_e;
endpackage

// File: rtl/title_sequencer_if.sv
// Bundle between the sequencer, the VGA timing/button inputs and the sprite/game consumers.
interface title_sequencer_if;
   import title_sequencer_pkg::*;
   logic [CORDW-1:0] pixel;
   logic [CORDW-1:0] line;
   logic             start_btn;
   logic             game_over;
   logic [XW-1:0]    title_x;
   logic             title_en;
   logic             game_run;
   logic             busy;

   modport master (output pixel, line, start_btn, game_over,
                   input  title_x, title_en, game_run, busy);
   modport slave  (input  pixel, line, start_btn, game_over,
                   output title_x, title_en, game_run, busy);
endinterface

// File: rtl/title_sequencer_btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge pulse; reusable for any raw button.
module btn_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);
   // sync_q[0..1] is the synchronizer, sync_q[2] the previous synced level
   logic [2:0] sync_q, sync_d;
   logic       pulse_q, pulse_d;

   always_comb begin
      sync_d  = {sync_q[1:0], btn_i};
      pulse_d = sync_q[1] & ~sync_q[2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;
endmodule

// File: rtl/title_sequencer.sv
// Frame-synchronous banner sequencer: slide-in, hold, blink, then gate gameplay until game over.
module title_sequencer
   import title_sequencer_pkg::*;
#(
   parameter logic [XW-1:0] START_X      = START_X_DEF,
   parameter logic [XW-1:0] TARGET_X     = TARGET_X_DEF,
   parameter int            STEP         = 4,
   parameter int            HOLD_FRAMES  = 60,
   parameter int            BLINK_FRAMES = 30
) (
   input logic              clk,
   input logic              rst,
   title_sequencer_if.slave bus
);
   localparam logic [CNTW-1:0] HOLD_LAST  = CNTW'(HOLD_FRAMES - 1);
   localparam logic [CNTW-1:0] BLINK_LAST = CNTW'(BLINK_FRAMES - 1);

   state_e          state_q, state_d;
   logic [XW-1:0]   x_q, x_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            en_q, en_d, run_q, run_d, busy_q, busy_d;
   logic            org_q, org_d;
   logic            frame_tick, start_pulse;
   logic [XW:0]     x_next;
   logic            clamp;

   btn_sync_edge u_start (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (bus.start_btn),
      .pulse_o (start_pulse)
   );

   // Single pulse per frame even if the origin coordinate is held for several clocks
   assign org_d      = (bus.pixel == '0) && (bus.line == '0);
   assign frame_tick = org_d & ~org_q;

   assign x_next = {1'b0, x_q} - (XW+1)'(STEP);
   assign clamp  = x_next[XW] | (x_next <= {1'b0, TARGET_X});

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      run_d   = run_q;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: if (frame_tick) begin
            state_d = ST_SLIDE_IN;
            x_d     = START_X;
            en_d    = 1'b1;
            busy_d  = 1'b1;
         end
         ST_SLIDE_IN: if (frame_tick) begin
            if (clamp) begin
               x_d     = TARGET_X;
               cnt_d   = '0;
               busy_d  = 1'b0;
               state_d = ST_HOLD;
            end else begin
               x_d = x_next[XW-1:0];
            end
         end
         ST_HOLD, ST_BLINK: begin
            // A start press beats a coincident frame tick; the count is dropped
            if (start_pulse) begin
               state_d = ST_RUN;
               en_d    = 1'b0;
               run_d   = 1'b1;
            end else if (frame_tick) begin
               if (state_q == ST_HOLD) begin
                  if (cnt_q == HOLD_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_BLINK;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (cnt_q == BLINK_LAST) begin
                  cnt_d = '0;
                  en_d  = ~en_q;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RUN: if (bus.game_over) begin
            state_d = ST_SLIDE_IN;
            x_d     = START_X;
            run_d   = 1'b0;
            en_d    = 1'b1;
            busy_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= START_X;
         cnt_q   <= '0;
         en_q    <= 1'b0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         org_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         run_q   <= run_d;
         busy_q  <= busy_d;
         org_q   <= org_d;
      end
   end

   assign bus.title_x  = x_q;
   assign bus.title_en = en_q;
   assign bus.game_run = run_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_title_sequencer.sv
// Directed bench for title_sequencer: two instances (STEP=4 and STEP=7) against a phase/frame-count model.
module tb_title_sequencer;
   import title_sequencer_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] pixel, line;
   logic       btn, go;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   title_sequencer_if bus4();
   title_sequencer_if bus7();

   assign bus4.pixel = pixel;  assign bus7.pixel = pixel;
   assign bus4.line  = line;   assign bus7.line  = line;
   assign bus4.start_btn = btn; assign bus7.start_btn = btn;
   assign bus4.game_over = go;  assign bus7.game_over = go;

   title_sequencer u_dut (.clk(clk), .rst(rst), .bus(bus4));
   title_sequencer #(.STEP(7)) u_dut7 (.clk(clk), .rst(rst), .bus(bus7));

   // Model: phase 0 idle, 1 slide, 2 hold, 3 blink, 4 run; n = frame ticks since phase entry
   int  ph[2]  = '{0, 0};
   int  n[2]   = '{0, 0};
   int  mx[2]  = '{640, 640};
   int  stp[2] = '{4, 7};
   bit  bh[4];
   bit  tc_prev, m_tick, m_sp, m_tc;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin ph[i] = 0; n[i] = 0; mx[i] = 640; end
         bh = '{0, 0, 0, 0};
         tc_prev = 0;
      end else begin
         m_tc    = (pixel == 0) && (line == 0);
         m_tick  = m_tc && !tc_prev;
         tc_prev = m_tc;
         // Start press is seen three edges after it is sampled
         m_sp = bh[2] && !bh[3];
         bh[3] = bh[2]; bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = btn;
         for (int i = 0; i < 2; i++) begin
            case (ph[i])
               0: if (m_tick) begin ph[i] = 1; n[i] = 0; mx[i] = 640; end
               1: if (m_tick) begin
                     n[i]++;
                     if (640 - stp[i] * n[i] <= 200) begin mx[i] = 200; ph[i] = 2; n[i] = 0; end
                     else mx[i] = 640 - stp[i] * n[i];
                  end
               2: if (m_sp) ph[i] = 4;
                  else if (m_tick) begin
                     n[i]++;
                     if (n[i] == 60) begin ph[i] = 3; n[i] = 0; end
                  end
               3: if (m_sp) ph[i] = 4;
                  else if (m_tick) n[i]++;
               default: if (go) begin ph[i] = 1; n[i] = 0; mx[i] = 640; end
            endcase
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [12:0] act, exp;
         logic        e_en;
         e_en = (ph[i] == 1) || (ph[i] == 2) || (ph[i] == 3 && ((n[i] / 30) % 2 == 0));
         exp  = {10'(mx[i]), e_en, ph[i] == 4, ph[i] == 1};
         act  = (i == 0) ? {bus4.title_x, bus4.title_en, bus4.game_run, bus4.busy}
                         : {bus7.title_x, bus7.title_en, bus7.game_run, bus7.busy};
         nvec++;
         if (act !== exp) begin
            nmis++;
            $display("FAIL model dut%0d t=%0t got x=%0d en=%b run=%b busy=%b want x=%0d en=%b run=%b busy=%b",
                     i, $time, act[12:3], act[2], act[1], act[0], exp[12:3], exp[2], exp[1], exp[0]);
         end
      end
   end

   int  pulses = 0;
   bit  cnt_en = 0;
   always @(negedge clk) if (cnt_en && u_dut.start_pulse) pulses++;

   task automatic chk(input string nm, input int act, input int exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Origin held for two clocks so a repeated compare must not double-tick
   task automatic frame();
      pixel = 0; line = 0; step(2);
      pixel = 10; line = 3; step(4);
   endtask

   initial begin
      pixel = 10; line = 3; btn = 0; go = 0;
      step(5);
      chk("rst_x", int'(bus4.title_x), 640);
      chk("rst_en", int'(bus4.title_en), 0);
      chk("rst_run", int'(bus4.game_run), 0);
      chk("rst_busy", int'(bus4.busy), 0);
      chk("rst_state", int'(u_dut.state_q), int'(ST_IDLE));
      rst = 0; step(3);
      chk("idle_en", int'(bus4.title_en), 0);

      frame();
      chk("slide0_x", int'(bus4.title_x), 640);
      chk("slide0_busy", int'(bus4.busy), 1);
      chk("slide0_en", int'(bus4.title_en), 1);
      frame(); chk("slide1_x", int'(bus4.title_x), 636);
      frame(); chk("slide2_x", int'(bus4.title_x), 632);

      btn = 1; step(2); btn = 0; step(6);
      chk("slide_ign_start", int'(u_dut.state_q), int'(ST_SLIDE_IN));
      go = 1; step(1); go = 0; step(1);
      chk("slide_ign_over", int'(bus4.busy), 1);

      repeat (53) frame();
      chk("mid_x4", int'(bus4.title_x), 420);
      chk("mid_x7", int'(bus7.title_x), 255);
      rst = 1; #2;
      chk("midrst_x", int'(bus4.title_x), 640);
      chk("midrst_en", int'(bus4.title_en), 0);
      chk("midrst_run", int'(bus4.game_run), 0);
      chk("midrst_state", int'(u_dut.state_q), int'(ST_IDLE));
      step(2); rst = 0; step(2);

      repeat (63) frame();
      chk("s7_x206", int'(bus7.title_x), 206);
      frame();
      chk("s7_clamp", int'(bus7.title_x), 200);
      chk("s7_hold", int'(u_dut7.state_q), int'(ST_HOLD));
      repeat (46) frame();
      chk("s4_x204", int'(bus4.title_x), 204);
      frame();
      chk("s4_x200", int'(bus4.title_x), 200);
      chk("s4_busy", int'(bus4.busy), 0);
      chk("s4_hold", int'(u_dut.state_q), int'(ST_HOLD));

      repeat (59) frame();
      chk("hold59", int'(u_dut.state_q), int'(ST_HOLD));
      frame();
      chk("blink_enter", int'(u_dut.state_q), int'(ST_BLINK));
      chk("blink_en0", int'(bus4.title_en), 1);
      repeat (30) frame(); chk("blink_en30", int'(bus4.title_en), 0);
      repeat (30) frame(); chk("blink_en60", int'(bus4.title_en), 1);

      btn = 1; step(2); btn = 0; step(3);
      chk("run_game", int'(bus4.game_run), 1);
      chk("run_en", int'(bus4.title_en), 0);
      chk("run_x", int'(bus4.title_x), 200);

      cnt_en = 1; btn = 1;
      repeat (100) frame();
      btn = 0; step(4); cnt_en = 0;
      chk("held_pulses", pulses, 1);
      chk("held_run", int'(bus4.game_run), 1);

      btn = 1; step(3); go = 1; step(1); go = 0;
      chk("over_run", int'(bus4.game_run), 0);
      chk("over_x", int'(bus4.title_x), 640);
      chk("over_state", int'(u_dut.state_q), int'(ST_SLIDE_IN));
      step(2); btn = 0;
      repeat (3) frame();
      chk("reslide_x", int'(bus4.title_x), 628);

      step(5);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
